// File: rtl/nanorv32_div_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : nanorv32_div_seq                                         |
// | Description : Sequential radix-2 restoring divider for RV32 DIV/DIVU/  |
// |               REM/REMU. It produces one quotient bit per BUSY cycle,   |
// |               so a result takes 33 cycles from accept to resp_valid.   |
// |               Optional macro NANORV32_DIV_EARLY_OUT_EN skips BUSY when |
// |               the divisor is zero or |dividend| < |divisor|.           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module nanorv32_div_seq #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_in_1,
   input  logic [DATA_W-1:0] req_in_2,
   input  logic              req_in_1_signed,
   input  logic              req_in_2_signed,
   input  logic              rem_op_sel,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_result
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [5:0] C_LAST_CNT = 6'(DATA_W - 1);

   state_t            state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] quo_q, quo_d;        // dividend shifts out, quotient shifts in
   logic [DATA_W-1:0] rem_q, rem_d;        // partial remainder
   logic [DATA_W-1:0] div_q, div_d;        // divisor magnitude
   logic              qneg_q, qneg_d;
   logic              rneg_q, rneg_d;
   logic              remsel_q, remsel_d;
   logic              bzero_q, bzero_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] result_q, result_d;

   logic              w_sign_a, w_sign_b;
   logic [DATA_W-1:0] w_mag_a, w_mag_b;
   logic              w_bzero;
   logic              w_early;
   logic [DATA_W:0]   w_shift;
   logic              w_fits;
   logic [DATA_W-1:0] w_sub;
   logic [DATA_W-1:0] w_quo_out, w_rem_out;

   // Operand signs and magnitudes taken straight from the request ports.
   assign w_sign_a = req_in_1[DATA_W-1] & req_in_1_signed;
   assign w_sign_b = req_in_2[DATA_W-1] & req_in_2_signed;
   assign w_mag_a  = w_sign_a ? (~req_in_1 + 1'b1) : req_in_1;
   assign w_mag_b  = w_sign_b ? (~req_in_2 + 1'b1) : req_in_2;
   assign w_bzero  = (req_in_2 == '0);

`ifdef NANORV32_DIV_EARLY_OUT_EN
   // Quotient is trivially all-ones (divide by zero) or zero (|a| < |b|).
   assign w_early = w_bzero | (w_mag_a < w_mag_b);
`else
   assign w_early = 1'b0;
`endif

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   // The shifted remainder is always below 2*divisor, so the 32-bit
   // subtraction cannot wrap when w_fits is set.
   assign w_shift = {rem_q, quo_q[DATA_W-1]};
   assign w_fits  = (w_shift >= {1'b0, div_q});
   assign w_sub   = w_shift[DATA_W-1:0] - div_q;

   // Sign fix-up; a zero divisor keeps the all-ones quotient unsigned-looking.
   assign w_quo_out = (qneg_q & ~bzero_q) ? (~quo_q + 1'b1) : quo_q;
   assign w_rem_out = rneg_q ? (~rem_q + 1'b1) : rem_q;

   assign req_ready   = (state_q == S_IDLE);
   assign resp_valid  = rvalid_q;
   assign resp_result = result_q;

   // Next-state logic: accept, iterate, single-cycle DONE, abort on req_valid drop.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = w_early ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            if (!req_valid) begin
               state_d = S_IDLE;
            end else if (cnt_q == C_LAST_CNT) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values: operand capture, division step, result latch.
   always_comb begin
      cnt_d    = cnt_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      div_d    = div_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      remsel_d = remsel_q;
      bzero_d  = bzero_q;
      rvalid_d = 1'b0;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               cnt_d    = '0;
               div_d    = w_mag_b;
               qneg_d   = w_sign_a ^ w_sign_b;
               rneg_d   = w_sign_a;
               remsel_d = rem_op_sel;
               bzero_d  = w_bzero;
               if (w_early) begin
                  quo_d = w_bzero ? '1 : '0;
                  rem_d = w_mag_a;
               end else begin
                  quo_d = w_mag_a;
                  rem_d = '0;
               end
            end
         end
         S_BUSY: begin
            if (!req_valid) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 6'd1;
               quo_d = {quo_q[DATA_W-2:0], w_fits};
               rem_d = w_fits ? w_sub : w_shift[DATA_W-1:0];
            end
         end
         S_DONE: begin
            cnt_d    = '0;
            rvalid_d = 1'b1;
            result_d = remsel_q ? w_rem_out : w_quo_out;
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         div_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         remsel_q <= 1'b0;
         bzero_q  <= 1'b0;
         rvalid_q <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         div_q    <= div_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         remsel_q <= remsel_d;
         bzero_q  <= bzero_d;
         rvalid_q <= rvalid_d;
         result_q <= result_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_nanorv32_div_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_nanorv32_div_seq                                      |
// | Description : Self-checking bench for nanorv32_div_seq: directed corner|
// |               cases, abort, mid-operation reset and random operands    |
// |               compared against an arithmetic reference model.          |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_nanorv32_div_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_in_1;
   logic [31:0] req_in_2;
   logic        req_in_1_signed;
   logic        req_in_2_signed;
   logic        rem_op_sel;
   logic        resp_valid;
   logic [31:0] resp_result;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] last_result;
   logic [31:0] ra, rb;
   logic        ras, rbs, rrs;
   int          seen;

   nanorv32_div_seq #(.DATA_W(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_in_1        (req_in_1),
      .req_in_2        (req_in_2),
      .req_in_1_signed (req_in_1_signed),
      .req_in_2_signed (req_in_2_signed),
      .rem_op_sel      (rem_op_sel),
      .resp_valid      (resp_valid),
      .resp_result     (resp_result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: RISC-V division semantics via 64-bit integer arithmetic.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 input logic as_f, input logic bs_f,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output int lat);
      longint va, vb, ma, mb;
      va = as_f ? longint'($signed(a)) : longint'(a);
      vb = bs_f ? longint'($signed(b)) : longint'(b);
      ma = (va < 0) ? -va : va;
      mb = (vb < 0) ? -vb : vb;
      if (vb == 0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else begin
         q = 32'(va / vb);
         r = 32'(va % vb);
      end
      lat = 33;
`ifdef NANORV32_DIV_EARLY_OUT_EN
      if (vb == 0 || ma < mb) lat = 1;
`else
      if (ma < 0 || mb < 0) lat = 0;   // unreachable: magnitudes are non-negative
`endif
   endfunction

   // Issue one request (entered #1 after a rising edge with the DUT idle).
   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic as_f, input logic bs_f, input logic rs);
      logic [31:0] eq, er, ex;
      int lat, k;
      model(a, b, as_f, bs_f, eq, er, lat);
      ex = rs ? er : eq;
      req_in_1 = a; req_in_2 = b;
      req_in_1_signed = as_f; req_in_2_signed = bs_f; rem_op_sel = rs;
      req_valid = 1'b1;
      chk({tag, " ready"}, {31'b0, req_ready}, 32'd1);
      @(posedge clk); #1;
      // Operands must be ignored once accepted.
      req_in_1 = $urandom; req_in_2 = $urandom;
      req_in_1_signed = 1'($urandom); req_in_2_signed = 1'($urandom);
      rem_op_sel = 1'($urandom);
      k = 0;
      while (k < 40 && resp_valid !== 1'b1) begin
         @(posedge clk); #1;
         k++;
      end
      req_valid = 1'b0;
      chk({tag, " latency"}, 32'(k), 32'(lat));
      chk({tag, " result"}, resp_result, ex);
      @(posedge clk); #1;
      chk({tag, " pulse"}, {31'b0, resp_valid}, 32'd0);
      chk({tag, " hold"}, resp_result, ex);
      last_result = ex;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0;
      req_in_1 = '0; req_in_2 = '0;
      req_in_1_signed = 1'b0; req_in_2_signed = 1'b0; rem_op_sel = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset ready", {31'b0, req_ready}, 32'd1);
      chk("reset valid", {31'b0, resp_valid}, 32'd0);
      chk("reset result", resp_result, 32'd0);
      last_result = '0;

      // Directed corner cases.
      do_op("u100/7 q", 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
      chk("u100/7 q const", last_result, 32'd14);
      do_op("u100/7 r", 32'd100, 32'd7, 1'b0, 1'b0, 1'b1);
      chk("u100/7 r const", last_result, 32'd2);
      do_op("s-7/2 q", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 1'b0);
      chk("s-7/2 q const", last_result, 32'hFFFF_FFFD);
      do_op("s-7/2 r", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 1'b1);
      chk("s-7/2 r const", last_result, 32'hFFFF_FFFF);
      do_op("u/0 q", 32'h1234, 32'd0, 1'b0, 1'b0, 1'b0);
      chk("u/0 q const", last_result, 32'hFFFF_FFFF);
      do_op("u/0 r", 32'h1234, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("u/0 r const", last_result, 32'h1234);
      do_op("s/0 q", 32'h1234, 32'd0, 1'b1, 1'b1, 1'b0);
      do_op("s/0 r", 32'h1234, 32'd0, 1'b1, 1'b1, 1'b1);
      do_op("sneg/0 q", 32'hFFFF_FF00, 32'd0, 1'b1, 1'b1, 1'b0);
      do_op("sneg/0 r", 32'hFFFF_FF00, 32'd0, 1'b1, 1'b1, 1'b1);
      do_op("ovf q", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
      chk("ovf q const", last_result, 32'h8000_0000);
      do_op("ovf r", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
      chk("ovf r const", last_result, 32'd0);

      // Abort: req_valid low during the 10th BUSY cycle.
      req_in_1 = 32'd1000; req_in_2 = 32'd3;
      req_in_1_signed = 1'b0; req_in_2_signed = 1'b0; rem_op_sel = 1'b0;
      req_valid = 1'b1;
      @(posedge clk); #1;
      repeat (9) begin @(posedge clk); #1; end
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("abort ready", {31'b0, req_ready}, 32'd1);
      chk("abort valid", {31'b0, resp_valid}, 32'd0);
      chk("abort result", resp_result, last_result);
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (resp_valid) seen++; end
      chk("abort no pulse", 32'(seen), 32'd0);
      do_op("after abort 9/3", 32'd9, 32'd3, 1'b0, 1'b0, 1'b0);
      chk("after abort const", last_result, 32'd3);

      // Reset during the 20th BUSY cycle.
      req_in_1 = 32'hDEAD_BEEF; req_in_2 = 32'h1357;
      req_valid = 1'b1;
      @(posedge clk); #1;
      repeat (19) begin @(posedge clk); #1; end
      rst = 1'b1; req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst valid", {31'b0, resp_valid}, 32'd0);
      chk("midrst result", resp_result, 32'd0);
      chk("midrst ready", {31'b0, req_ready}, 32'd1);
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (resp_valid) seen++; end
      chk("midrst no pulse", 32'(seen), 32'd0);
      chk("midrst result hold", resp_result, 32'd0);
      last_result = '0;

      // Random operands against the reference model.
      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         if (i % 5 == 0) ra = $urandom_range(0, 100);
         case (i % 4)
            0: rb = $urandom;
            1: rb = $urandom_range(1, 255);
            2: rb = $urandom_range(0, 3);
            default: rb = 32'hFFFF_FFFF - $urandom_range(0, 3);
         endcase
         ras = 1'($urandom);
         rbs = 1'($urandom);
         rrs = 1'($urandom);
         do_op("rand", ra, rb, ras, rbs, rrs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
